// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one imem request at a time
// and holds the returned instruction (with pre-split fields) for decode.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  oprand,
    output logic        inst_fault,
    input  logic        npc_take,
    input  logic [31:0] npc_target,
    input  logic        flush_valid,
    input  logic [31:0] flush_pc
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] inst_r;
    logic        kill;
    logic        fault_r;
    logic        misaligned;

    assign misaligned = (pc[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            kill    <= 1'b0;
            inst_r  <= NOP_INST;
            fault_r <= 1'b0;
        end else if (flush_valid) begin
            pc <= flush_pc;
            case (state)
                REQ: begin
                    // An accepted request still owes a response; mark it stale.
                    if (!misaligned && imem_req_ready) begin
                        kill  <= 1'b1;
                        state <= WAIT;
                    end else begin
                        state <= REQ;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        kill  <= 1'b0;
                        state <= REQ;
                    end else begin
                        kill <= 1'b1;
                    end
                end
                default: state <= REQ;
            endcase
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (misaligned) begin
                        fault_r <= 1'b1;
                        inst_r  <= NOP_INST;
                        state   <= HOLD;
                    end else if (imem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= REQ;
                        end else begin
                            inst_r  <= imem_rsp_err ? NOP_INST : imem_rsp_data;
                            fault_r <= imem_rsp_err;
                            state   <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        pc    <= npc_take ? npc_target : pc + 32'd4;
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign imem_req_valid = (state == REQ) && !misaligned;
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == HOLD);
    assign inst           = inst_r;
    assign inst_pc        = pc;
    assign opcode         = inst_r[6:0];
    assign funct3         = inst_r[14:12];
    assign oprand         = inst_r[31:25];
    assign inst_fault     = fault_r;

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized scoreboard bench for ifu_fetch: a PC-stream model predicts
// every instruction handed to decode; a monitor pops and compares.
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  oprand;
    logic        inst_fault;
    logic        npc_take;
    logic [31:0] npc_target;
    logic        flush_valid;
    logic [31:0] flush_pc;

    ifu_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .imem_rsp_err(imem_rsp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc),
        .opcode(opcode), .funct3(funct3), .oprand(oprand),
        .inst_fault(inst_fault),
        .npc_take(npc_take), .npc_target(npc_target),
        .flush_valid(flush_valid), .flush_pc(flush_pc)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
        logic        fault;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] model_pc;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_acc = 0;
    logic        acc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, req);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0093;
    endfunction

    function automatic logic err_of(input logic [31:0] a);
        return (a[5:2] == 4'hD);
    endfunction

    function automatic exp_t exp_of(input logic [31:0] a);
        exp_t r;
        r.pc = a;
        if (a[1:0] != 2'b00 || err_of(a)) begin
            r.word  = NOP_INST;
            r.fault = 1'b1;
        end else begin
            r.word  = mem_word(a);
            r.fault = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'h8000_0000 | {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
        if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
        return a;
    endfunction

    // Memory responder: one response per accepted request, 1..4 cycles later.
    logic        hs;
    logic [31:0] hs_addr;
    logic        pending;
    logic [31:0] paddr;
    int          cnt;

    initial begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        imem_rsp_err   = 1'b0;
        pending = 1'b0;
        paddr = 32'd0;
        cnt = 0;
        forever begin
            @(negedge clk);
            hs = imem_req_valid && imem_req_ready && !rst;
            hs_addr = imem_req_addr;
            @(posedge clk);
            #2;
            imem_rsp_valid = 1'b0;
            if (rst) begin
                pending = 1'b0;
            end else begin
                if (hs) begin
                    pending = 1'b1;
                    cnt = $urandom_range(0, 3);
                    paddr = hs_addr;
                end
                if (pending) begin
                    if (cnt == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = mem_word(paddr);
                        imem_rsp_err   = err_of(paddr);
                        pending = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
            imem_req_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: checks every decode handshake and hold stability.
    logic        prev_hold = 1'b0;
    logic [31:0] prev_inst;
    logic [31:0] prev_pc;
    logic        prev_fault;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (imem_req_valid) chk("req_align", {30'd0, imem_req_addr[1:0]}, 32'd0);
                if (prev_hold) begin
                    chk("hold_valid", {31'd0, inst_valid}, 32'd1);
                    chk("hold_inst", inst, prev_inst);
                    chk("hold_pc", inst_pc, prev_pc);
                    chk("hold_fault", {31'd0, inst_fault}, {31'd0, prev_fault});
                end
                if (inst_valid && inst_ready && !flush_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_inst", inst_pc, 32'hxxxx_xxxx);
                    end else begin
                        e = exp_q.pop_front();
                        chk("inst_pc", inst_pc, e.pc);
                        chk("inst", inst, e.word);
                        chk("inst_fault", {31'd0, inst_fault}, {31'd0, e.fault});
                        chk("opcode", {25'd0, opcode}, {25'd0, e.word[6:0]});
                        chk("funct3", {29'd0, funct3}, {29'd0, e.word[14:12]});
                        chk("oprand", {25'd0, oprand}, {25'd0, e.word[31:25]});
                    end
                end
                prev_hold  = inst_valid && !inst_ready && !flush_valid;
                prev_inst  = inst;
                prev_pc    = inst_pc;
                prev_fault = inst_fault;
            end
        end
    end

    task automatic step(input logic fl, input logic [31:0] fpc, input logic rdy,
                        input logic tk, input logic [31:0] tgt, output logic ok);
        @(posedge clk);
        #1;
        flush_valid = fl;
        flush_pc    = fpc;
        inst_ready  = rdy;
        npc_take    = tk;
        npc_target  = tgt;
        ok = 1'b0;
        if (fl) begin
            exp_q.delete();
            model_pc = fpc;
            exp_q.push_back(exp_of(model_pc));
        end else if (inst_valid && rdy) begin
            model_pc = tk ? tgt : model_pc + 32'd4;
            exp_q.push_back(exp_of(model_pc));
            ok = 1'b1;
        end
    endtask

    task automatic restart_model();
        exp_q.delete();
        model_pc = RESET_PC;
        exp_q.push_back(exp_of(RESET_PC));
    endtask

    initial begin
        logic found;
        rst = 1'b1;
        inst_ready = 1'b0;
        npc_take = 1'b0;
        npc_target = 32'd0;
        flush_valid = 1'b0;
        flush_pc = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_addr", imem_req_addr, RESET_PC);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, NOP_INST);
        chk("rst_inst_pc", inst_pc, RESET_PC);
        chk("rst_opcode", {25'd0, opcode}, 32'h13);
        chk("rst_funct3", {29'd0, funct3}, 32'd0);
        chk("rst_oprand", {25'd0, oprand}, 32'd0);
        chk("rst_fault", {31'd0, inst_fault}, 32'd0);
        restart_model();
        rst = 1'b0;

        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (imem_req_valid) begin
                found = 1'b1;
                chk("first_addr", imem_req_addr, RESET_PC);
            end
        end
        if (!found) chk("first_req_timeout", 32'd0, 32'd1);

        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 24) == 0, rand_addr(), $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), rand_addr(), acc);
            if (acc) n_acc++;
        end

        // PC wrap on a sequential accept at the top of the address space.
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'd0, acc);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, acc);
            found = acc;
        end
        if (!found) chk("wrap_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        chk("wrap_addr", imem_req_addr, 32'd0);

        // Reset while a request is in flight.
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, acc);
            @(negedge clk);
            found = imem_req_valid && imem_req_ready;
        end
        if (!found) chk("wait_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_addr", imem_req_addr, RESET_PC);
        chk("midrst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("midrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        repeat (2) @(negedge clk);
        restart_model();
        rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 24) == 0, rand_addr(), $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), rand_addr(), acc);
            if (acc) n_acc++;
        end
        chk("accepted_enough", {31'd0, n_acc > 100}, 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
